// File: rtl/demux_1_16_collector_if.sv
// ---------------------------------------------------------------------------
// demux_1_16_collector_if
// Bundles the serial input side and the parallel word output side of the
// 1:16 collector.
//   Input side : in_bit, in_valid, in_ready, sel_mode, select, flush, slot_en
//   Output side: w, w_mask, w_valid, w_ready
// Modports:
//   master - the environment: drives the bit stream and controls, consumes words
//   slave  - the collector itself
// ---------------------------------------------------------------------------
interface demux_1_16_collector_if #(
    parameter int N     = 16,
    parameter int SEL_W = 4
);
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic             sel_mode;
    logic [SEL_W-1:0] select;
    logic             flush;
    logic [N-1:0]     slot_en;
    logic [N-1:0]     w;
    logic [N-1:0]     w_mask;
    logic             w_valid;
    logic             w_ready;

    modport master (
        output in_bit, in_valid, sel_mode, select, flush, w_ready,
        input  in_ready, slot_en, w, w_mask, w_valid
    );

    modport slave (
        input  in_bit, in_valid, sel_mode, select, flush, w_ready,
        output in_ready, slot_en, w, w_mask, w_valid
    );
endinterface

// File: rtl/demux_1_16_collector.sv
// ---------------------------------------------------------------------------
// demux_1_16_collector
// Collects a serial bit stream into a 16-bit parallel word. Each accepted
// bit lands in the slot addressed either by an internal auto-increment
// counter (sel_mode=0) or by the external select (sel_mode=1, select[3:2] =
// group, select[1:0] = bit in group, so the slot index is select itself).
// When every slot has been written, or on a flush with at least one slot
// written, the word and its write mask are offered on a valid/ready output.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - demux_1_16_collector_if.slave
//          in_bit/in_valid/in_ready : serial input handshake
//          sel_mode/select          : slot addressing mode / external slot
//          flush                    : emit a partially filled word
//          slot_en                  : one-hot target slot, zero when not ready
//          w/w_mask/w_valid/w_ready : collected word output handshake
//
// N and SEL_W are carried for documentation; only N=16, SEL_W=4 is valid.
// ---------------------------------------------------------------------------
module demux_1_16_collector #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    demux_1_16_collector_if.slave        bus
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_cnt;
    logic [N-1:0]     r_w;
    logic [N-1:0]     r_w_mask;
    logic             r_in_ready;
    logic             r_w_valid;

    logic [SEL_W-1:0] w_slot;
    logic [N-1:0]     w_slot_dec;
    logic [N-1:0]     w_wr_en;
    logic [N-1:0]     w_word_next;
    logic [N-1:0]     w_mask_next;
    logic             w_accept;
    logic             w_emit;

    // The group/bit split of select concatenates straight back into the
    // slot index, so no arithmetic is needed.
    assign w_slot   = bus.sel_mode ? bus.select : r_cnt;
    assign w_accept = bus.in_valid & r_in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            assign w_slot_dec[gi]  = (w_slot == SEL_W'(gi));
            assign w_wr_en[gi]     = w_accept & w_slot_dec[gi];
            assign w_word_next[gi] = w_wr_en[gi] ? bus.in_bit : r_w[gi];
            assign w_mask_next[gi] = r_w_mask[gi] | w_wr_en[gi];
        end
    endgenerate

    // Decisions use the post-write mask so the bit accepted on the completing
    // or flushing edge is part of the emitted word. A flush with nothing
    // written and nothing arriving leaves the mask empty and is ignored.
    assign w_emit = (&w_mask_next) | (bus.flush & (|w_mask_next));

    assign bus.slot_en  = w_slot_dec & {N{r_in_ready}};
    assign bus.in_ready = r_in_ready;
    assign bus.w_valid  = r_w_valid;
    assign bus.w        = r_w;
    assign bus.w_mask   = r_w_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_cnt      <= '0;
            r_w        <= '0;
            r_w_mask   <= '0;
            r_in_ready <= 1'b1;
            r_w_valid  <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    r_w      <= w_word_next;
                    r_w_mask <= w_mask_next;
                    // Select-mode writes leave the counter where it was so
                    // auto mode resumes from the same slot.
                    if (w_accept && !bus.sel_mode) begin
                        r_cnt <= r_cnt + SEL_W'(1);
                    end
                    if (w_emit) begin
                        r_state    <= HOLD;
                        r_in_ready <= 1'b0;
                        r_w_valid  <= 1'b1;
                    end
                end
                HOLD: begin
                    // Inputs and flush are ignored here; the word is frozen.
                    // Ready comes back one cycle after the take, leaving a
                    // one-cycle bubble per word.
                    if (bus.w_ready) begin
                        r_state    <= FILL;
                        r_cnt      <= '0;
                        r_w        <= '0;
                        r_w_mask   <= '0;
                        r_in_ready <= 1'b1;
                        r_w_valid  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1_16_collector.sv
module tb_demux_1_16_collector;

    logic clk;
    logic rst;

    demux_1_16_collector_if bus ();

    demux_1_16_collector #(.N(16), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entry: {expected w, expected w_mask}
    logic [31:0] exp_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h @%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h @%0t", name, act, $time);
        end
    endfunction

    // Monitor: every newly presented word is matched against the scoreboard.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.w_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {bus.w, bus.w_mask}, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_w", {16'h0, bus.w}, {16'h0, e[31:16]});
                    chk("word_mask", {16'h0, bus.w_mask}, {16'h0, e[15:0]});
                end
            end
            prev_valid = bus.w_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_word();
        bus.w_ready = 1'b1;
        tick();
        bus.w_ready = 1'b0;
        @(negedge clk);
        chk("release_valid", {31'h0, bus.w_valid}, 32'h0);
        chk("release_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("release_w", {16'h0, bus.w}, 32'h0);
        chk("release_mask", {16'h0, bus.w_mask}, 32'h0);
    endtask

    task automatic auto_word(input logic [15:0] data, input string tag);
        bus.sel_mode = 1'b0;
        exp_q.push_back({data, 16'hFFFF});
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = data[i];
            @(negedge clk);
            chk({tag, "_slot_en"}, {16'h0, bus.slot_en}, {16'h0, 16'h1 << i});
            if (i == 15) chk({tag, "_no_early_valid"}, {31'h0, bus.w_valid}, 32'h0);
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_lat1"}, {31'h0, bus.w_valid}, 32'h1);
        chk({tag, "_ready_low"}, {31'h0, bus.in_ready}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [3:0]  s;
        rst          = 1'b1;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b0;
        bus.sel_mode = 1'b0;
        bus.select   = 4'h0;
        bus.flush    = 1'b0;
        bus.w_ready  = 1'b0;
        #23;
        rst = 1'b0;
        tick();

        // Reset state
        @(negedge clk);
        chk("rst_valid", {31'h0, bus.w_valid}, 32'h0);
        chk("rst_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("rst_w", {16'h0, bus.w}, 32'h0);
        chk("rst_mask", {16'h0, bus.w_mask}, 32'h0);
        chk("rst_slot_en", {16'h0, bus.slot_en}, 32'h0001);
        tick();

        // Auto fill 0xA5C3
        auto_word(16'hA5C3, "auto");
        release_word();

        // Select mode, slots 15..0 descending, in_bit = slot[0]
        bus.sel_mode = 1'b1;
        exp_q.push_back({16'hAAAA, 16'hFFFF});
        for (int k = 15; k >= 0; k--) begin
            s = 4'(k);
            bus.select   = s;
            bus.in_bit   = s[0];
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sel_valid", {31'h0, bus.w_valid}, 32'h1);
        release_word();

        // Next word: select group 2, bit 1 -> slot 9
        bus.select   = 4'b1001;
        bus.in_bit   = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("sel_slot9_en", {16'h0, bus.slot_en}, 32'h0200);
        tick();
        bus.in_valid = 1'b0;
        // Flush with non-empty mask and no accepted bit emits the partial word
        exp_q.push_back({16'h0200, 16'h0200});
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_partial_valid", {31'h0, bus.w_valid}, 32'h1);
        release_word();

        // Flush with 5th auto bit: 1,1,0,1,1
        bus.sel_mode = 1'b0;
        d = 16'h001B;
        exp_q.push_back({16'h001B, 16'h001F});
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = d[i];
            bus.flush    = (i == 4);
            tick();
        end
        bus.flush = 1'b0;

        // Backpressure: in_valid and flush driven, word must stay frozen
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
            bus.flush    = c[0];
            @(negedge clk);
            chk("bp_w", {16'h0, bus.w}, 32'h001B);
            chk("bp_slot_en", {16'h0, bus.slot_en}, 32'h0);
            chk("bp_valid", {31'h0, bus.w_valid}, 32'h1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        release_word();
        // Counter back at slot 0 after the take
        @(negedge clk);
        chk("bp_cnt_slot0", {16'h0, bus.slot_en}, 32'h0001);

        // Flush with empty mask: ignored
        bus.flush = 1'b1;
        tick();
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_empty_valid", {31'h0, bus.w_valid}, 32'h0);
        chk("flush_empty_ready", {31'h0, bus.in_ready}, 32'h1);

        // Overwrite slot 3
        bus.sel_mode = 1'b1;
        bus.select   = 4'd3;
        bus.in_bit   = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        @(negedge clk);
        chk("ovw_first_w", {16'h0, bus.w}, 32'h0008);
        bus.in_bit = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("ovw_w", {16'h0, bus.w}, 32'h0);
        chk("ovw_mask", {16'h0, bus.w_mask}, 32'h0008);
        chk("ovw_fill", {31'h0, bus.in_ready}, 32'h1);

        // Async reset after 8 auto bits (counter still at 0)
        bus.sel_mode = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_mask", {16'h0, bus.w_mask}, 32'h00FF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_w", {16'h0, bus.w}, 32'h0);
        chk("arst_mask", {16'h0, bus.w_mask}, 32'h0);
        chk("arst_valid", {31'h0, bus.w_valid}, 32'h0);
        #3;
        rst = 1'b0;
        tick();
        auto_word(16'h3C96, "post_rst");
        release_word();

        chk("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
